// File: rtl/our_spsram_arbiter_pkg.sv
// rtl/our_spsram_arbiter_pkg.sv - shared types, widths and round-robin pick for the SRAM arbiter
//
// Purpose: holds the arbiter state enum, the SRAM data and byte-enable widths,
// and rr_pick(). rr_pick() works on a fixed 8-bit request vector so that one
// function serves every NUM_REQ in 2..8. Callers zero-extend the request
// vector and keep only the low NUM_REQ bits of the result.
// Ports: none (package).

package our_spsram_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DATA_WIDTH = 128;
  localparam int BE_WIDTH   = 16;
  localparam int MAX_REQ    = 8;

  // One-hot pick of the first asserted request, scanning upward from ptr
  // and wrapping modulo n. Indices at or above n are never considered.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [2:0]         sel;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      sel = 3'((int'(ptr) + i) % n);
      if ((i < n) && !found && req[sel]) begin
        pick[sel] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/our_spsram_arbiter_if.sv
// rtl/our_spsram_arbiter_if.sv - requester and SRAM pin bundle for the shared-SRAM arbiter
//
// Purpose: groups the requester handshake bus and the SRAM pins.
// Ports (signals):
//   req_i/we_i/lock_i  per-requester request, write, burst-lock
//   addr_i/wdata_i/be_i  per-requester slices (requester k owns slice k)
//   gnt_o, rvalid_o, rdata_o  grant, response strobe, broadcast read data
//   sram_a_o/sram_cen_o/sram_wen_o/sram_d_o/sram_q_i  SRAM pins
// Modports: slave = arbiter side, master = requesters plus SRAM model.

interface our_spsram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 21
);
  import our_spsram_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            we_i;
  logic [NUM_REQ-1:0]            lock_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ*BE_WIDTH-1:0]   be_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic [ADDR_WIDTH-1:0]         sram_a_o;
  logic                          sram_cen_o;
  logic [BE_WIDTH-1:0]           sram_wen_o;
  logic [DATA_WIDTH-1:0]         sram_d_o;
  logic [DATA_WIDTH-1:0]         sram_q_i;

  modport slave (
    input  req_i, we_i, lock_i, addr_i, wdata_i, be_i, sram_q_i,
    output gnt_o, rvalid_o, rdata_o, sram_a_o, sram_cen_o, sram_wen_o, sram_d_o
  );

  modport master (
    output req_i, we_i, lock_i, addr_i, wdata_i, be_i, sram_q_i,
    input  gnt_o, rvalid_o, rdata_o, sram_a_o, sram_cen_o, sram_wen_o, sram_d_o
  );

endinterface

// File: rtl/our_spsram_arbiter_rr.sv
// rtl/our_spsram_arbiter_rr.sv - round-robin pick with its rotating priority pointer
//
// Purpose: combinational one-hot pick over i_req starting at the pointer,
// plus the pointer register itself. The owner of this block does not decide
// when the pointer moves; the caller asserts i_adv with the index whose
// successor becomes the new pointer.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (pointer -> 0)
//   i_req         eligible requests (already masked by the caller)
//   i_adv         move the pointer this cycle
//   i_adv_idx     pointer becomes (i_adv_idx + 1) mod NUM_REQ
//   o_gnt         one-hot pick, zero when i_req is zero

module our_rr_arbiter
  import our_spsram_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  input  logic [IDX_W-1:0]   i_adv_idx,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [IDX_W-1:0]   r_ptr;
  logic [MAX_REQ-1:0] w_pick;
  logic               w_unused_pick;

  assign w_pick        = rr_pick(MAX_REQ'(i_req), 3'(r_ptr), NUM_REQ);
  assign o_gnt         = w_pick[NUM_REQ-1:0];
  // Bits above NUM_REQ are always zero because the request was zero-extended.
  assign w_unused_pick = ^w_pick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : i_adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/our_spsram_arbiter.sv
// rtl/our_spsram_arbiter.sv - round-robin arbiter sharing one 128-bit single-port SRAM
//
// Purpose: grants at most one requester per cycle (combinational one-hot
// gnt_o), drives the SRAM pins for that access, and returns a registered
// per-requester rvalid_o one cycle later with read data broadcast on rdata_o.
// A requester that is granted with lock_i set keeps exclusive ownership for up
// to MAX_BURST consecutive grants.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus           our_spsram_arbiter_if.slave (requesters + SRAM pins)
//   perf_gnt_cnt_o, perf_stall_cnt_o  only when OUR_SPSRAM_ARB_PERF_EN is
//                 defined: saturating per-requester grant counters and a
//                 stall counter (cycles where some request is not granted)
// Optional feature macro: OUR_SPSRAM_ARB_PERF_EN

module our_spsram_arbiter
  import our_spsram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 21,
  parameter int MAX_BURST  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef OUR_SPSRAM_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]  perf_gnt_cnt_o,
  output logic [31:0]            perf_stall_cnt_o,
`endif
  our_spsram_arbiter_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_own, w_own_nxt;
  logic [7:0]            r_burst_cnt, w_burst_cnt_nxt;
  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_gnt_any;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_adv;
  logic [IDX_W-1:0]      w_adv_idx;
  logic [NUM_REQ-1:0]    r_rvalid;
  logic                  r_resp_we;
  logic [ADDR_WIDTH-1:0] w_cur_a, r_sram_a;
  logic [DATA_WIDTH-1:0] w_cur_d, r_sram_d;
  logic [BE_WIDTH-1:0]   w_cur_be;

  // In LOCKED only the owner may be granted, even if it is idle and others wait.
  always_comb begin
    w_elig = '0;
    if (!rst_i) begin
      if (r_state == LOCKED) begin
        w_elig[r_own] = bus.req_i[r_own];
      end else begin
        w_elig = bus.req_i;
      end
    end
  end

  our_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_req     (w_elig),
    .i_adv     (w_adv),
    .i_adv_idx (w_adv_idx),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) w_gnt_idx = IDX_W'(k);
    end
  end

  assign w_gnt_any = |w_gnt;

  // Next-state logic. Entering LOCKED deliberately leaves the pointer alone;
  // leaving LOCKED (lock dropped, burst limit hit, or owner idle) moves it
  // past the owner so the others get the next turn.
  always_comb begin
    w_state_nxt     = r_state;
    w_own_nxt       = r_own;
    w_burst_cnt_nxt = r_burst_cnt;
    w_adv           = 1'b0;
    w_adv_idx       = w_gnt_idx;
    case (r_state)
      ARB: begin
        if (w_gnt_any) begin
          if (bus.lock_i[w_gnt_idx]) begin
            w_state_nxt     = LOCKED;
            w_own_nxt       = w_gnt_idx;
            w_burst_cnt_nxt = 8'd1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (w_gnt_any) begin
          w_burst_cnt_nxt = r_burst_cnt + 8'd1;
          if (!bus.lock_i[r_own] || ((9'(r_burst_cnt) + 9'd1) == 9'(MAX_BURST))) begin
            w_state_nxt     = ARB;
            w_adv           = 1'b1;
            w_adv_idx       = r_own;
            w_burst_cnt_nxt = '0;
          end
        end else begin
          w_state_nxt     = ARB;
          w_adv           = 1'b1;
          w_adv_idx       = r_own;
          w_burst_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign w_cur_a  = bus.addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_cur_d  = bus.wdata_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_cur_be = bus.be_i[w_gnt_idx*BE_WIDTH +: BE_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ARB;
      r_own       <= '0;
      r_burst_cnt <= '0;
      r_rvalid    <= '0;
      r_resp_we   <= 1'b0;
      r_sram_a    <= '0;
      r_sram_d    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_own       <= w_own_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rvalid    <= w_gnt;
      r_resp_we   <= w_gnt_any & bus.we_i[w_gnt_idx];
      if (w_gnt_any) begin
        r_sram_a <= w_cur_a;
        r_sram_d <= w_cur_d;
      end
    end
  end

  // Address and data hold the last granted values while idle so the SRAM
  // inputs do not toggle when nothing is accessed.
  assign bus.gnt_o      = w_gnt;
  assign bus.sram_cen_o = ~w_gnt_any;
  assign bus.sram_wen_o = (w_gnt_any && bus.we_i[w_gnt_idx]) ? ~w_cur_be : '1;
  assign bus.sram_a_o   = w_gnt_any ? w_cur_a : r_sram_a;
  assign bus.sram_d_o   = w_gnt_any ? w_cur_d : r_sram_d;

  // A reset arriving the cycle after a grant swallows that response.
  assign bus.rvalid_o   = rst_i ? '0 : r_rvalid;
  assign bus.rdata_o    = (!rst_i && (|r_rvalid) && !r_resp_we) ? bus.sram_q_i : '0;

`ifdef OUR_SPSRAM_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] r_perf_gnt;
  logic [31:0]           r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_gnt   <= '0;
      r_perf_stall <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_gnt[k] && (r_perf_gnt[k*32 +: 32] != 32'hFFFF_FFFF)) begin
          r_perf_gnt[k*32 +: 32] <= r_perf_gnt[k*32 +: 32] + 32'd1;
        end
      end
      if ((|(bus.req_i & ~w_gnt)) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_gnt_cnt_o   = r_perf_gnt;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule
